// File: rtl/operand_loader_pkg.sv
// Shared definitions for the operand loader.
//   state_t   : loader FSM state encoding (2'b11 is illegal, recovers to IDLE)
//   OPERAND_W : default operand width
//   timer_w() : timer width needed to count up to a given timeout value
package operand_pkg;

  localparam int OPERAND_W = 8;

  typedef enum logic [1:0] {
    IDLE   = 2'b00,
    HAVE_A = 2'b01,
    FULL   = 2'b10
  } state_t;

  // A disabled timeout (0) still gets a 1-bit timer so no zero-width vectors appear.
  function automatic int timer_w(input int timeout);
    return (timeout < 1) ? 1 : $clog2(timeout + 1);
  endfunction

endpackage

// File: rtl/operand_loader_timeout_ctr.sv
// Idle-cycle timer for a half-loaded operand pair.
// Ports:
//   i_clk, i_rst : clock, async active-high reset
//   i_clear      : force the timer back to zero
//   i_enable     : one idle cycle has elapsed while waiting for operand B
//   o_expire     : combinational pulse on the idle cycle where the limit is reached
module op_timeout_ctr
  import operand_pkg::*;
#(
  parameter int TIMEOUT = 16
) (
  input  logic i_clk,
  input  logic i_rst,
  input  logic i_clear,
  input  logic i_enable,
  output logic o_expire
);

  localparam int TW = timer_w(TIMEOUT);

  logic [TW-1:0] r_timer;
  logic          w_at_limit;

  // TIMEOUT = 0 disables the limit entirely, so the timer never moves.
  assign w_at_limit = (TIMEOUT != 0) && (r_timer == TW'(TIMEOUT - 1));
  assign o_expire   = i_enable && w_at_limit;

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_timer <= '0;
    end else if (i_clear) begin
      r_timer <= '0;
    end else if (i_enable && !w_at_limit && (TIMEOUT != 0)) begin
      r_timer <= r_timer + 1'b1;
    end
  end

endmodule

// File: rtl/operand_loader.sv
// Two-beat operand loader in front of the adder/logic datapath.
// Beat 1 on i_in_data becomes operand A, beat 2 becomes operand B; the pair
// is then held on o_op_a/o_op_b with o_out_valid until i_out_ready.
// Ports:
//   i_clk, i_rst           : clock, async active-high reset
//   i_flush                : synchronous abort of any partial or held pair
//   i_in_valid, i_in_data  : upstream beat; o_in_ready is the accept signal
//   o_out_valid, i_out_ready, o_op_a, o_op_b : downstream pair handshake
//   o_timeout_err          : one-cycle pulse when a half pair is dropped
//   o_pair_cnt             : pairs handed off, wrapping
//
// state  | meaning
// IDLE   | waiting for operand A
// HAVE_A | A captured, waiting for operand B (timer running)
// FULL   | complete pair presented downstream, no beats accepted
module operand_loader
  import operand_pkg::*;
#(
  parameter int WIDTH   = OPERAND_W,
  parameter int TIMEOUT = 16,
  parameter int CNT_W   = 8
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_flush,
  input  logic             i_in_valid,
  input  logic [WIDTH-1:0] i_in_data,
  output logic             o_in_ready,
  output logic             o_out_valid,
  input  logic             i_out_ready,
  output logic [WIDTH-1:0] o_op_a,
  output logic [WIDTH-1:0] o_op_b,
  output logic             o_timeout_err,
  output logic [CNT_W-1:0] o_pair_cnt
);

  state_t           r_state;
  logic [WIDTH-1:0] r_op_a;
  logic [WIDTH-1:0] r_op_b;
  logic             r_out_valid;
  logic             r_timeout_err;
  logic [CNT_W-1:0] r_pair_cnt;

  logic w_tmo_clear;
  logic w_tmo_enable;
  logic w_tmo_expire;

  // Illegal encoding 2'b11 also refuses beats; it falls back to IDLE next edge.
  assign o_in_ready = ((r_state == IDLE) || (r_state == HAVE_A)) && !i_flush;

  assign w_tmo_clear  = (r_state != HAVE_A) || i_flush;
  assign w_tmo_enable = (r_state == HAVE_A) && !i_in_valid && !i_flush;

  op_timeout_ctr #(
    .TIMEOUT (TIMEOUT)
  ) u_timeout (
    .i_clk    (i_clk),
    .i_rst    (i_rst),
    .i_clear  (w_tmo_clear),
    .i_enable (w_tmo_enable),
    .o_expire (w_tmo_expire)
  );

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_state       <= IDLE;
      r_op_a        <= '0;
      r_op_b        <= '0;
      r_out_valid   <= 1'b0;
      r_timeout_err <= 1'b0;
      r_pair_cnt    <= '0;
    end else begin
      r_timeout_err <= 1'b0;
      if (i_flush) begin
        // Flush beats a same-cycle handoff: the pair is discarded, not counted.
        r_state     <= IDLE;
        r_op_a      <= '0;
        r_op_b      <= '0;
        r_out_valid <= 1'b0;
      end else begin
        case (r_state)
          IDLE: begin
            if (i_in_valid) begin
              r_op_a  <= i_in_data;
              r_state <= HAVE_A;
            end
          end
          HAVE_A: begin
            // A B beat on the expiry cycle completes the pair instead of timing out.
            if (i_in_valid) begin
              r_op_b      <= i_in_data;
              r_out_valid <= 1'b1;
              r_state     <= FULL;
            end else if (w_tmo_expire) begin
              r_timeout_err <= 1'b1;
              r_state       <= IDLE;
            end
          end
          FULL: begin
            if (i_out_ready) begin
              r_out_valid <= 1'b0;
              r_pair_cnt  <= r_pair_cnt + 1'b1;
              r_state     <= IDLE;
            end
          end
          default: begin
            r_out_valid <= 1'b0;
            r_state     <= IDLE;
          end
        endcase
      end
    end
  end

  assign o_op_a        = r_op_a;
  assign o_op_b        = r_op_b;
  assign o_out_valid   = r_out_valid;
  assign o_timeout_err = r_timeout_err;
  assign o_pair_cnt    = r_pair_cnt;

endmodule

// File: doc/operand_loader.md
Name: operand_loader

Overview:
- Upstream stage of the 8-bit adder/logic datapath (sum, AND, XOR of two operands).
- Accepts operands one beat at a time on a shared input bus with a valid/ready handshake: first beat is operand A, second beat is operand B.
- Holds the captured pair stable and presents it downstream with a valid/ready handshake.
- Includes a timeout that drops a half-loaded pair, plus a completed-pair counter.

Parameters:
- WIDTH, 8, operand width in bits.
- TIMEOUT, 16, idle cycles allowed in HAVE_A before A is dropped; 0 disables the timeout.
- CNT_W, 8, width of the completed-pair counter.

Ports:
- clk  input  1  single clock, rising edge.
- rst  input  1  asynchronous, active-high reset.
- flush  input  1  synchronous abort of any partial or held pair.
- in_valid  input  1  upstream beat valid.
- in_data  input  WIDTH  operand beat.
- in_ready  output  1  loader can accept a beat this cycle.
- out_valid  output  1  op_a/op_b hold a complete pair.
- out_ready  input  1  downstream (adder stage) accepts the pair.
- op_a  output  WIDTH  captured first operand.
- op_b  output  WIDTH  captured second operand.
- timeout_err  output  1  one-cycle pulse when a half pair is dropped.
- pair_cnt  output  CNT_W  number of pairs handed off, wraps modulo 2^CNT_W.

Behaviour:
- Reset (async assert, sync release): state IDLE; op_a=0, op_b=0, out_valid=0, timeout_err=0, pair_cnt=0, timer=0.
- All outputs are registered except in_ready, which is decoded from state: in_ready = (state != FULL) && !flush.
- States:
  - IDLE: on in_valid, capture in_data into op_a, clear timer, go to HAVE_A.
  - HAVE_A: on in_valid, capture in_data into op_b and go to FULL.
    - Otherwise, if TIMEOUT != 0, increment timer.
    - When the timer reaches TIMEOUT-1 with no beat, go to IDLE, pulse timeout_err for 1 cycle, and keep op_a unchanged (not valid).
  - FULL: out_valid=1, and op_a/op_b are held stable.
    - On out_ready: go to IDLE, out_valid drops the next cycle, pair_cnt += 1 with wrap (0xFF -> 0x00 at CNT_W=8).
    - No beat is accepted in FULL, even during the handoff cycle. Minimum period is 3 cycles per pair.
- Latency: a B beat accepted at edge k gives out_valid=1 after edge k, visible in cycle k+1.
- Simultaneous events:
  - HAVE_A with in_valid and timeout expiry in the same cycle: capturing B wins; no timeout_err.
  - flush in any state: next state IDLE, out_valid=0, timer=0, op_a/op_b cleared to 0, no timeout_err, pair_cnt unchanged.
    - A FULL pair with out_ready in the same cycle as flush is not counted.
    - in_ready is 0 during flush, so no beat is consumed.
  - rst mid-pair: immediate return to the reset values; the partial pair is lost silently.
- Invariants:
  - timeout_err is never high in two consecutive cycles.
  - out_valid is never high outside FULL.

Decomposition:
- Shared package `operand_pkg`:
  - state typedef, 2 bits: IDLE=2'b00, HAVE_A=2'b01, FULL=2'b10; 2'b11 illegal, recovers to IDLE.
  - OPERAND_W=8 default.
  - Helper constant for timer width = clog2(TIMEOUT+1).
- One sub-module `op_timeout_ctr`:
  - Inputs: clear, enable.
  - Output: expire pulse.
  - Parameterised by TIMEOUT.

Test Plan:
- After reset, send beats 0x3C then 0x05 on back-to-back cycles with out_ready=1 -> out_valid high one cycle after the second beat, op_a=0x3C, op_b=0x05, pair_cnt=1, in_ready low while FULL.
- Hold out_ready=0 for 10 cycles after a pair 0xFF/0x01 -> op_a/op_b stable, in_ready=0, and new in_valid beats are ignored; then out_ready=1 -> IDLE, pair_cnt increments once.
- TIMEOUT=16: send A=0x11, then no beat for 16 cycles -> timeout_err pulses exactly once on the 16th idle cycle; state IDLE; the next beat 0x22 is captured as op_a.
- Send A, then send B on exactly the expiry cycle -> pair completes with op_b=B and no timeout_err.
- Assert flush in HAVE_A, and separately in FULL with out_ready=1 -> IDLE, out_valid=0, op_a=op_b=0, pair_cnt unchanged.
- Complete 256 pairs (CNT_W=8) -> pair_cnt wraps 0xFF -> 0x00. Assert rst mid-pair -> all outputs return to reset values immediately.
